// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the 5-stage RV32I core.
//   - ALU function codes consumed by the EX-stage ALU
//   - RV32I major opcode constants
//   - operand-select enums for the ALU command
//   - helper mapping funct3 to the ALU code for OP/OP-IMM
package core_pkg;

  localparam int XLEN = 32;

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_EQ   = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_e;

  // funct3 -> ALU code shared by OP and OP-IMM (SUB/SRA handled by caller)
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational decode of RV32I opcode/funct3/funct7_5 into
// the EX-stage ALU command fields.
// Ports:
//   opcode, funct3, funct7_5, rd  in   instruction fields from ID
//   alu_ctrl                      out  ALU function code
//   op1_sel, op2_sel              out  operand source selects
//   regwrite                      out  instruction writes a non-zero rd
//   is_branch, br_invert          out  conditional branch and sense inversion
//   illegal                       out  unsupported encoding
// Illegal encodings leave every command field at its neutral default.
module alu_ctrl_dec
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [4:0] rd,
  output logic [3:0] alu_ctrl,
  output op1_sel_e   op1_sel,
  output op2_sel_e   op2_sel,
  output logic       regwrite,
  output logic       is_branch,
  output logic       br_invert,
  output logic       illegal
);

  logic writes_rd_s;

  // Main decode table
  always_comb begin
    alu_ctrl    = ALU_ADD;
    op1_sel     = OP1_RS1;
    op2_sel     = OP2_RS2;
    writes_rd_s = 1'b0;
    is_branch   = 1'b0;
    br_invert   = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b101 && funct7_5) begin
          illegal = 1'b1;                         // SRA not supported
        end else if (funct3 == 3'b000 && funct7_5) begin
          alu_ctrl    = ALU_SUB;
          writes_rd_s = 1'b1;
        end else begin
          alu_ctrl    = alu_from_funct3(funct3);
          writes_rd_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // bit 30 is immediate data here except for the shift-right form
        if (funct3 == 3'b101 && funct7_5) begin
          illegal = 1'b1;                         // SRAI not supported
        end else begin
          alu_ctrl    = alu_from_funct3(funct3);
          op2_sel     = OP2_IMM;
          writes_rd_s = 1'b1;
        end
      end
      OPC_LOAD: begin
        op2_sel     = OP2_IMM;
        writes_rd_s = 1'b1;
      end
      OPC_STORE: begin
        op2_sel = OP2_IMM;
      end
      OPC_LUI: begin
        op1_sel     = OP1_ZERO;
        op2_sel     = OP2_IMM;
        writes_rd_s = 1'b1;
      end
      OPC_AUIPC: begin
        op1_sel     = OP1_PC;
        op2_sel     = OP2_IMM;
        writes_rd_s = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op1_sel     = OP1_PC;
        op2_sel     = OP2_FOUR;
        writes_rd_s = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: begin
            alu_ctrl  = ALU_EQ;
            is_branch = 1'b1;
            br_invert = funct3[0];
          end
          3'b100, 3'b101: begin
            alu_ctrl  = ALU_SLT;
            is_branch = 1'b1;
            br_invert = funct3[0];
          end
          3'b110, 3'b111: begin
            alu_ctrl  = ALU_SLTU;
            is_branch = 1'b1;
            br_invert = funct3[0];
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign regwrite = writes_rd_s && (rd != 5'd0);

endmodule

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX pipeline register and ALU operand issue.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_*                            decoded instruction fields from ID
//   stall, flush                    hold / bubble the stage (flush wins)
//   exmem_*, memwb_*                forwarding sources (EX/MEM has priority)
//   alu_op1, alu_op2, alu_ctrl      ALU command (operands forwarded, combinational)
//   ex_valid, ex_pc, ex_rd          latched instruction context
//   ex_regwrite, ex_is_branch,
//   ex_br_invert, ex_illegal        latched control
//   ex_store_data                   forwarded rs2 for stores
// Operands are built only from latched state and the forwarding inputs, so
// no id_* input reaches an output without passing through the register.
module ex_issue_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_regwrite,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_ctrl,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_is_branch,
  output logic            ex_br_invert,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_illegal
);

  // Decoder outputs (ahead of the register)
  logic [3:0] dec_alu_ctrl_s;
  op1_sel_e   dec_op1_sel_s;
  op2_sel_e   dec_op2_sel_s;
  logic       dec_regwrite_s;
  logic       dec_is_branch_s;
  logic       dec_br_invert_s;
  logic       dec_illegal_s;

  // ID/EX register contents
  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] rs1_data_r;
  logic [XLEN-1:0] rs2_data_r;
  logic [XLEN-1:0] imm_r;
  logic [4:0]      rs1_r;
  logic [4:0]      rs2_r;
  logic [4:0]      rd_r;
  logic [3:0]      alu_ctrl_r;
  op1_sel_e        op1_sel_r;
  op2_sel_e        op2_sel_r;
  logic            regwrite_r;
  logic            is_branch_r;
  logic            br_invert_r;
  logic            illegal_r;

  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic [XLEN-1:0] op2_raw_s;

  alu_ctrl_dec u_dec (
    .opcode    (id_opcode),
    .funct3    (id_funct3),
    .funct7_5  (id_funct7_5),
    .rd        (id_rd),
    .alu_ctrl  (dec_alu_ctrl_s),
    .op1_sel   (dec_op1_sel_s),
    .op2_sel   (dec_op2_sel_s),
    .regwrite  (dec_regwrite_s),
    .is_branch (dec_is_branch_s),
    .br_invert (dec_br_invert_s),
    .illegal   (dec_illegal_s)
  );

  // ID/EX register: flush > stall > load; an invalid ID slot loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      pc_r        <= '0;
      rs1_data_r  <= '0;
      rs2_data_r  <= '0;
      imm_r       <= '0;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      rd_r        <= 5'd0;
      alu_ctrl_r  <= ALU_ADD;
      op1_sel_r   <= OP1_RS1;
      op2_sel_r   <= OP2_RS2;
      regwrite_r  <= 1'b0;
      is_branch_r <= 1'b0;
      br_invert_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      valid_r     <= 1'b0;
      pc_r        <= '0;
      rs1_data_r  <= '0;
      rs2_data_r  <= '0;
      imm_r       <= '0;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      rd_r        <= 5'd0;
      alu_ctrl_r  <= ALU_ADD;
      op1_sel_r   <= OP1_RS1;
      op2_sel_r   <= OP2_RS2;
      regwrite_r  <= 1'b0;
      is_branch_r <= 1'b0;
      br_invert_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (!stall) begin
      valid_r     <= 1'b1;
      pc_r        <= id_pc;
      rs1_data_r  <= id_rs1_data;
      rs2_data_r  <= id_rs2_data;
      imm_r       <= id_imm;
      rs1_r       <= id_rs1;
      rs2_r       <= id_rs2;
      rd_r        <= id_rd;
      alu_ctrl_r  <= dec_alu_ctrl_s;
      op1_sel_r   <= dec_op1_sel_s;
      op2_sel_r   <= dec_op2_sel_s;
      regwrite_r  <= dec_regwrite_s;
      is_branch_r <= dec_is_branch_s;
      br_invert_r <= dec_br_invert_s;
      illegal_r   <= dec_illegal_s;
    end else begin
      valid_r     <= valid_r;
    end
  end

  // Forwarding select: youngest producer (EX/MEM) first, x0 never forwarded
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      rs,
                                              input logic [XLEN-1:0] reg_data,
                                              input logic            em_we,
                                              input logic [4:0]      em_rd,
                                              input logic [XLEN-1:0] em_res,
                                              input logic            mw_we,
                                              input logic [4:0]      mw_rd,
                                              input logic [XLEN-1:0] mw_res);
    logic [XLEN-1:0] v;
    if (em_we && (em_rd != 5'd0) && (em_rd == rs)) begin
      v = em_res;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) begin
      v = mw_res;
    end else begin
      v = reg_data;
    end
    return v;
  endfunction

  // Forwarded source operands
  always_comb begin
    fwd_rs1_s = fwd_sel(rs1_r, rs1_data_r, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
    fwd_rs2_s = fwd_sel(rs2_r, rs2_data_r, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
  end

  // Operand muxes; shift amounts are reduced to 5 bits after forwarding
  always_comb begin
    case (op1_sel_r)
      OP1_RS1:  alu_op1 = fwd_rs1_s;
      OP1_PC:   alu_op1 = pc_r;
      OP1_ZERO: alu_op1 = '0;
      default:  alu_op1 = '0;
    endcase
    case (op2_sel_r)
      OP2_RS2:  op2_raw_s = fwd_rs2_s;
      OP2_IMM:  op2_raw_s = imm_r;
      OP2_FOUR: op2_raw_s = 32'd4;
      default:  op2_raw_s = '0;
    endcase
    if (alu_ctrl_r == ALU_SLL || alu_ctrl_r == ALU_SRL) begin
      alu_op2 = {27'd0, op2_raw_s[4:0]};
    end else begin
      alu_op2 = op2_raw_s;
    end
  end

  assign alu_ctrl      = alu_ctrl_r;
  assign ex_valid      = valid_r;
  assign ex_pc         = pc_r;
  assign ex_rd         = rd_r;
  assign ex_regwrite   = regwrite_r;
  assign ex_is_branch  = is_branch_r;
  assign ex_br_invert  = br_invert_r;
  assign ex_illegal    = illegal_r;
  assign ex_store_data = fwd_rs2_s;

endmodule

// File: tb/tb_ex_issue_stage.sv
// tb_ex_issue_stage: directed bench for ex_issue_stage. A reference model
// records which instruction the stage should hold and derives every output
// from the RV32I rules; a compare process checks it each falling edge, and
// directed steps add hand-computed literal checks.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = 32'd0, id_rs1_data = 32'd0, id_rs2_data = 32'd0, id_imm = 32'd0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic [6:0]  id_opcode = 7'd0;
  logic [2:0]  id_funct3 = 3'd0;
  logic        id_funct7_5 = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        exmem_regwrite = 1'b0, memwb_regwrite = 1'b0;
  logic [4:0]  exmem_rd = 5'd0, memwb_rd = 5'd0;
  logic [31:0] exmem_result = 32'd0, memwb_result = 32'd0;
  logic [31:0] alu_op1, alu_op2, ex_pc, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_regwrite, ex_is_branch, ex_br_invert, ex_illegal;

  int n_vec = 0;
  int n_bad = 0;

  ex_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_branch(ex_is_branch),
    .ex_br_invert(ex_br_invert), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction the stage is supposed to hold
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f75;
  } ins_t;

  typedef struct packed {
    logic [31:0] op1, op2, pc, store;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        valid, regw, br, inv, ill;
  } exp_t;

  ins_t held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) held <= '0;
    else if (flush) held <= '0;
    else if (stall) held <= held;
    else if (!id_valid) held <= '0;
    else held <= '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm,
                   id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_funct7_5};
  end

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return d;
    if (exmem_regwrite && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  // Expected outputs from the RV32I issue rules
  function automatic exp_t model(input ins_t i);
    exp_t e;
    logic [3:0] f3map [8];
    logic [31:0] a, b;
    logic writes;
    f3map = '{4'd0, 4'd9, 4'd4, 4'd3, 4'd7, 4'd8, 4'd6, 4'd5};
    e = '0;
    if (!i.valid) return e;
    a = fwd(i.rs1, i.rs1d);
    b = fwd(i.rs2, i.rs2d);
    e.valid = 1'b1; e.pc = i.pc; e.rd = i.rd; e.store = b;
    e.op1 = a; e.op2 = b; writes = 1'b0;
    if (i.opc == 7'b0110011) begin
      if (i.f3 == 3'd5 && i.f75) e.ill = 1'b1;
      else begin e.ctrl = (i.f3 == 3'd0 && i.f75) ? 4'd1 : f3map[i.f3]; writes = 1'b1; end
    end else if (i.opc == 7'b0010011) begin
      if (i.f3 == 3'd5 && i.f75) e.ill = 1'b1;
      else begin e.ctrl = f3map[i.f3]; e.op2 = i.imm; writes = 1'b1; end
    end else if (i.opc == 7'b0000011 || i.opc == 7'b0100011) begin
      e.op2 = i.imm; writes = (i.opc == 7'b0000011);
    end else if (i.opc == 7'b0110111) begin
      e.op1 = 32'd0; e.op2 = i.imm; writes = 1'b1;
    end else if (i.opc == 7'b0010111) begin
      e.op1 = i.pc; e.op2 = i.imm; writes = 1'b1;
    end else if (i.opc == 7'b1101111 || i.opc == 7'b1100111) begin
      e.op1 = i.pc; e.op2 = 32'd4; writes = 1'b1;
    end else if (i.opc == 7'b1100011) begin
      if (i.f3 == 3'd2 || i.f3 == 3'd3) e.ill = 1'b1;
      else begin
        e.br = 1'b1; e.inv = i.f3[0];
        e.ctrl = (i.f3 < 3'd4) ? 4'd2 : (i.f3 < 3'd6) ? 4'd4 : 4'd3;
      end
    end else e.ill = 1'b1;
    e.regw = writes && !e.ill && (i.rd != 5'd0);
    if (e.ctrl == 4'd8 || e.ctrl == 4'd9) e.op2 = e.op2 % 32;
    return e;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    e = model(held);
    chk("m_valid", {31'd0, ex_valid}, {31'd0, e.valid});
    chk("m_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
    chk("m_pc", ex_pc, e.pc);
    chk("m_rd", {27'd0, ex_rd}, {27'd0, e.rd});
    chk("m_regw", {31'd0, ex_regwrite}, {31'd0, e.regw});
    chk("m_br", {30'd0, ex_is_branch, ex_br_invert}, {30'd0, e.br, e.inv});
    chk("m_ill", {31'd0, ex_illegal}, {31'd0, e.ill});
    if (!e.ill) begin
      chk("m_op1", alu_op1, e.op1);
      chk("m_op2", alu_op2, e.op2);
      chk("m_store", ex_store_data, e.store);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [31:0] pc);
    id_valid = 1'b1; id_opcode = opc; id_funct3 = f3; id_funct7_5 = f75;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_pc = pc;
  endtask

  task automatic no_fwd();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  initial begin
    // reset state
    repeat (2) step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    issue(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h100);
    step();
    chk("add_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("add_op1", alu_op1, 32'd5);
    chk("add_op2", alu_op2, 32'd7);
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    chk("add_regw", {31'd0, ex_regwrite}, 32'd1);

    // SUB x4,x1,x2 with both stages producing x1
    issue(7'b0110011, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd9, 32'd7, 32'd0, 32'h104);
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd100;
    memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'd50;
    step();
    chk("sub_ctrl", {28'd0, alu_ctrl}, 32'd1);
    chk("sub_fwd_exmem", alu_op1, 32'd100);
    exmem_rd = 5'd0;
    #1 chk("sub_x0_nofwd", alu_op1, 32'd50);
    memwb_regwrite = 1'b0;
    #1 chk("sub_regdata", alu_op1, 32'd9);
    no_fwd();

    // BGE with rs1=-1, rs2=2
    issue(7'b1100011, 3'd5, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd16, 32'h108);
    step();
    chk("bge_ctrl", {28'd0, alu_ctrl}, 32'd4);
    chk("bge_br", {30'd0, ex_is_branch, ex_br_invert}, 32'd3);
    chk("bge_regw", {31'd0, ex_regwrite}, 32'd0);

    // SLLI x5,x6,35 -> shift amount 3
    issue(7'b0010011, 3'd1, 1'b0, 5'd6, 5'd3, 5'd5, 32'd1, 32'd0, 32'd35, 32'h10C);
    step();
    chk("slli_ctrl", {28'd0, alu_ctrl}, 32'd9);
    chk("slli_op2", alu_op2, 32'd3);

    // SRAI is unsupported
    issue(7'b0010011, 3'd5, 1'b1, 5'd6, 5'd2, 5'd5, 32'd1, 32'd0, 32'h402, 32'h110);
    step();
    chk("srai_ill", {31'd0, ex_illegal}, 32'd1);
    chk("srai_regw", {31'd0, ex_regwrite}, 32'd0);

    // ADDI with negative immediate (bit 30 set) stays ADD
    issue(7'b0010011, 3'd0, 1'b1, 5'd1, 5'd0, 5'd2, 32'd10, 32'd0, 32'hFFFF_FC00, 32'h114);
    step();
    chk("addi_ctrl", {28'd0, alu_ctrl}, 32'd0);

    // ADD x7 then stall three cycles while MEM/WB produces x1
    issue(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd7, 32'd11, 32'd2, 32'd0, 32'h118);
    step();
    stall = 1'b1;
    issue(7'b0110011, 3'd6, 1'b0, 5'd8, 5'd9, 5'd10, 32'd1, 32'd1, 32'd0, 32'h11C);
    memwb_regwrite = 1'b1; memwb_rd = 5'd1;
    for (int k = 0; k < 3; k++) begin
      memwb_result = 32'd200 + k;
      step();
      chk("stall_rd", {27'd0, ex_rd}, 32'd7);
      chk("stall_pc", ex_pc, 32'h118);
      chk("stall_op1", alu_op1, 32'd200 + k);
    end
    no_fwd();

    // stall and flush together -> bubble
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rd", {27'd0, ex_rd}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // JAL x1 -> pc + 4
    issue(7'b1101111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd64, 32'h200);
    step();
    chk("jal_op1", alu_op1, 32'h200);
    chk("jal_op2", alu_op2, 32'd4);

    // ADD into x0 writes nothing
    issue(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'd0, 32'h204);
    step();
    chk("x0_regw", {31'd0, ex_regwrite}, 32'd0);

    // id_valid low captures a bubble
    id_valid = 1'b0;
    step();
    chk("idv0_valid", {31'd0, ex_valid}, 32'd0);

    // reset pulsed mid-stall clears immediately
    issue(7'b0010111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'h1000, 32'h300);
    step();
    chk("auipc_op1", alu_op1, 32'h300);
    stall = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_rd", {27'd0, ex_rd}, 32'd0);
    chk("arst_op", alu_op1 | alu_op2, 32'd0);
    #1 rst_n = 1'b1;
    stall = 1'b0;
    issue(7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h1234_5000, 32'h400);
    step();
    chk("lui_valid", {31'd0, ex_valid}, 32'd1);
    chk("lui_op1", alu_op1, 32'd0);
    chk("lui_op2", alu_op2, 32'h1234_5000);
    chk("lui_rd", {27'd0, ex_rd}, 32'd9);
    id_valid = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline register and operand issue for the 5-stage core. Latches decoded RV32I instruction fields from ID, turns them into the EX-stage ALU command (alu_op1, alu_op2, alu_ctrl), resolves EX/MEM and MEM/WB forwarding, and supports stall and flush. It is the producer side of the ALU command interface; its alu_* outputs wire directly to the ALU.

## Interface
- XLEN, 32, datapath width
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  instruction PC
- id_rs1_data, id_rs2_data  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate, already formed by ID
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_opcode  in  7; id_funct3  in  3; id_funct7_5  in  1 (instr[30])
- stall  in  1  hold ID/EX contents (load-use hazard)
- flush  in  1  replace ID/EX contents with a bubble (branch redirect)
- exmem_regwrite  in  1; exmem_rd  in  5; exmem_result  in  32
- memwb_regwrite  in  1; memwb_rd  in  5; memwb_result  in  32
- alu_op1, alu_op2  out  32  ALU operands (forwarded)
- alu_ctrl  out  4  ALU function code
- ex_valid  out  1; ex_pc  out  32; ex_rd  out  5; ex_regwrite  out  1
- ex_is_branch  out  1; ex_br_invert  out  1  branch taken when (alu_res[0] ^ ex_br_invert)
- ex_store_data  out  32  forwarded rs2 for stores
- ex_illegal  out  1  unsupported encoding latched

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 EQ, 3 SLTU, 4 SLT, 5 AND, 6 OR, 7 XOR, 8 SRL, 9 SLL.
- Decode (registered with the stage):
  - OP 0110011: funct3 000 ADD/SUB by funct7_5; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (funct7_5=1, SRA: illegal); 110 OR; 111 AND. op2 = rs2.
  - OP-IMM 0010011: same map, no SUB; op2 = imm; SRAI illegal.
  - LOAD 0000011 / STORE 0100011: ADD, op1 = rs1, op2 = imm.
  - LUI 0110111: ADD, op1 = 0, op2 = imm. AUIPC 0010111: ADD, op1 = pc, op2 = imm.
  - JAL 1101111 / JALR 1100111: ADD, op1 = pc, op2 = 4.
  - BRANCH 1100011: BEQ/BNE→EQ, BLT/BGE→SLT, BLTU/BGEU→SLTU; op2 = rs2; invert = 1 for BNE/BGE/BGEU.
  - Any other opcode: ex_illegal = 1, alu_ctrl = 0, ex_regwrite = 0.
- Shift ops: alu_op2 masked to {27'b0, op2[4:0]} after forwarding.
- ex_regwrite = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR with rd ≠ 0; else 0.
- Forwarding per source (rs1, rs2), combinational from latched index: EX/MEM match (regwrite, rd ≠ 0, rd == rs) wins; else MEM/WB match; else latched register data. x0 never forwarded.
- Bubble: ex_valid = 0, ex_regwrite = 0, ex_is_branch = 0, ex_illegal = 0, alu_ctrl = 0, rd = 0.

## Timing
- Reset (async, rst_n low): every registered field 0; ex_valid = 0; alu_op1/op2 = 0, alu_ctrl = 0.
- Latency: ID fields visible on ex_* one cycle after the capturing edge.
- Per edge priority: flush > stall > load. flush=1 loads a bubble regardless of stall. stall=1 (no flush) holds all registers; forwarding muxes stay live so values arriving during the stall update operands.
- id_valid=0 on a load edge captures a bubble.
- alu_op1/op2 are combinational from registers and forwarding inputs; no combinational path from id_* to any output.
- Reset asserted mid-stall clears the stage; first post-reset edge loads normally.

## Structure
- Shared package core_pkg: ALU code constants (ALU_ADD..ALU_SLL), RV32I opcode constants, op1/op2 select enums.
- Sub-module alu_ctrl_dec: combinational opcode/funct3/funct7_5 → alu_ctrl, op selects, regwrite, is_branch, invert, illegal; instantiated ahead of the ID/EX register.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7, no forwarding → next cycle alu_ctrl=0, op1=5, op2=7, ex_rd=3, ex_regwrite=1.
- SUB x4,x1,x2 with exmem_rd=1 result 100 and memwb_rd=1 result 50 → op1=100 (EX/MEM priority); exmem_rd=0 with regwrite → no forward.
- BGE rs1=-1, rs2=2 → alu_ctrl=4, ex_is_branch=1, ex_br_invert=1, ex_regwrite=0.
- SLLI x5,x6,0x23 (imm 35) → alu_ctrl=9, op2=3; SRAI → ex_illegal=1, ex_regwrite=0.
- stall held 3 cycles while memwb_result changes → outputs hold, op1 tracks forwarded value; stall and flush together → bubble, ex_valid=0.
- rst_n pulsed low mid-operation → all outputs 0 immediately (asynchronous); next instruction issues one edge after release.
